// File: rtl/ldpc_pkg.sv
// ldpc_pkg: shared widths and LLR/magnitude types for the min-sum check node
package ldpc_pkg;
    localparam int LLR_W = 8;
    localparam int DEG   = 6;
    typedef logic [LLR_W-1:0] llr_t;
    typedef logic [LLR_W-2:0] mag_t;
endpackage

// File: rtl/ldpc_min2_finder.sv
// ldpc_min2_finder: smallest and second-smallest of six magnitudes plus the lowest index of the smallest
module ldpc_min2_finder
    import ldpc_pkg::*;
(
    input  mag_t       mag_i [DEG],
    output mag_t       min1_o,
    output mag_t       min2_o,
    output logic [2:0] idx_o
);
    mag_t       min1, min2;
    logic [2:0] idx;
    // strict compare keeps the lowest index on ties and lets min2 pick up the tied value
    always_comb begin
        min1 = mag_i[0];
        min2 = '1;
        idx  = '0;
        for (int j = 1; j < DEG; j++) begin
            if (mag_i[j] < min1) begin
                min2 = min1;
                min1 = mag_i[j];
                idx  = 3'(j);
            end else if (mag_i[j] < min2) begin
                min2 = mag_i[j];
            end
        end
    end
    assign min1_o = min1;
    assign min2_o = min2;
    assign idx_o  = idx;
endmodule

// File: rtl/ldpc_minsigner.sv
// ldpc_minsigner: two-stage pipelined min-sum check node producing six extrinsic LLRs
module ldpc_minsigner
    import ldpc_pkg::*;
(
    input  logic i_clock,
    input  logic i_reset,
    input  llr_t i_data_a0,
    input  llr_t i_data_a1,
    input  llr_t i_data_a2,
    input  llr_t i_data_a3,
    input  llr_t i_data_a4,
    input  llr_t i_data_a5,
    input  logic i_valid,
    output llr_t o_data_a0,
    output llr_t o_data_a1,
    output llr_t o_data_a2,
    output llr_t o_data_a3,
    output llr_t o_data_a4,
    output llr_t o_data_a5,
    output logic o_valid
);
    llr_t           a [DEG];
    mag_t           mag_d [DEG];
    logic [DEG-1:0] sign_d;
    mag_t           min1_d, min2_d;
    logic [2:0]     idx_d;
    mag_t           mag_q [DEG];
    logic [DEG-1:0] sign_q;
    mag_t           min1_q, min2_q;
    logic [2:0]     idx_q;
    logic           v1_q;
    mag_t           m_d [DEG];
    llr_t           out_d [DEG];
    llr_t           out_q [DEG];
    logic           v2_q;
    logic           tot;

    // split inputs into sign bits and magnitudes, saturating |-128| to 127
    always_comb begin
        a[0] = i_data_a0;
        a[1] = i_data_a1;
        a[2] = i_data_a2;
        a[3] = i_data_a3;
        a[4] = i_data_a4;
        a[5] = i_data_a5;
        for (int k = 0; k < DEG; k++) begin
            sign_d[k] = a[k][LLR_W-1];
            mag_d[k]  = (a[k] == 8'h80) ? 7'h7f : a[k][LLR_W-1] ? mag_t'(-a[k]) : a[k][LLR_W-2:0];
        end
    end

    ldpc_min2_finder u_min2 (
        .mag_i  (mag_d),
        .min1_o (min1_d),
        .min2_o (min2_d),
        .idx_o  (idx_d)
    );

    // stage 1: capture magnitudes, minima and signs of each accepted check node
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            v1_q   <= 1'b0;
            sign_q <= '0;
            min1_q <= '0;
            min2_q <= '0;
            idx_q  <= '0;
            for (int k = 0; k < DEG; k++) mag_q[k] <= '0;
        end else begin
            v1_q <= i_valid;
            if (i_valid) begin
                sign_q <= sign_d;
                min1_q <= min1_d;
                min2_q <= min2_d;
                idx_q  <= idx_d;
                for (int k = 0; k < DEG; k++) mag_q[k] <= mag_d[k];
            end
        end
    end

    // each lane excludes itself: min2 for the argmin lane, own sign removed from the total parity
    always_comb begin
        tot = ^sign_q;
        for (int k = 0; k < DEG; k++) begin
            m_d[k]   = (3'(k) == idx_q) ? min2_q : min1_q;
            out_d[k] = (tot ^ sign_q[k]) ? llr_t'(-{1'b0, m_d[k]}) : {1'b0, m_d[k]};
        end
    end

    // stage 2: register signed extrinsic outputs and the output valid
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            v2_q <= 1'b0;
            for (int k = 0; k < DEG; k++) out_q[k] <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) for (int k = 0; k < DEG; k++) out_q[k] <= out_d[k];
        end
    end

    assign o_data_a0 = out_q[0];
    assign o_data_a1 = out_q[1];
    assign o_data_a2 = out_q[2];
    assign o_data_a3 = out_q[3];
    assign o_data_a4 = out_q[4];
    assign o_data_a5 = out_q[5];
    assign o_valid   = v2_q;
endmodule

// File: tb/tb_ldpc_minsigner.sv
// tb_ldpc_minsigner: directed-vector self-checking bench for the min-sum check node
module tb_ldpc_minsigner;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] din [6];
    logic [7:0] od  [6];
    logic       ov;
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] vin  [4][6];
    logic [7:0] vexp [4][6];

    always #5 clk = ~clk;

    ldpc_minsigner dut (
        .i_clock   (clk),
        .i_reset   (rst),
        .i_data_a0 (din[0]),
        .i_data_a1 (din[1]),
        .i_data_a2 (din[2]),
        .i_data_a3 (din[3]),
        .i_data_a4 (din[4]),
        .i_data_a5 (din[5]),
        .i_valid   (valid),
        .o_data_a0 (od[0]),
        .o_data_a1 (od[1]),
        .o_data_a2 (od[2]),
        .o_data_a3 (od[3]),
        .o_data_a4 (od[4]),
        .o_data_a5 (od[5]),
        .o_valid   (ov)
    );

    task automatic set_in(input int v);
        for (int k = 0; k < 6; k++) din[k] = vin[v][k];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        valid = 1'b0;
        for (int k = 0; k < 6; k++) din[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b want 0", ov);
        end
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (od[k] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_data[%0d]: got %0d want 0", k, $signed(od[k]));
            end
        end
    endtask

    task automatic test_single(input int v);
        @(posedge clk);
        #1 set_in(v);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL vec%0d_early: o_valid got %b want 0 one cycle after input", v, ov);
        end
        @(negedge clk);
        n_chk++;
        if (ov !== 1'b1) begin
            n_fail++;
            $display("FAIL vec%0d_latency: o_valid got %b want 1 two cycles after input", v, ov);
        end
        for (int k = 0; k < 6; k++) begin
            n_chk++;
            if (od[k] !== vexp[v][k]) begin
                n_fail++;
                $display("FAIL vec%0d_out[%0d]: got %0d want %0d", v, k, $signed(od[k]), $signed(vexp[v][k]));
            end
        end
        @(negedge clk);
        n_chk++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL vec%0d_pulse: o_valid got %b want 0 after single pulse", v, ov);
        end
    endtask

    task automatic test_idle;
        int pulses = 0;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int k = 0; k < 6; k++) din[k] = 8'(8'h35 + k * 17);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (ov) pulses++;
            if (c % 7 == 0) din[c % 6] = 8'($urandom);
        end
        n_chk++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL idle_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int seen = 0;
        fork
            begin
                for (int v = 0; v < 4; v++) begin
                    @(posedge clk);
                    #1 set_in(v);
                    valid = 1'b1;
                end
                @(posedge clk);
                #1 valid = 1'b0;
            end
            begin
                int waited = 0;
                @(negedge clk);
                while (ov !== 1'b1 && waited < 20) begin
                    @(negedge clk);
                    waited++;
                end
                n_chk++;
                if (ov !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_start: o_valid got %b want 1 within 20 cycles", ov);
                end else begin
                    for (int v = 0; v < 4; v++) begin
                        n_chk++;
                        if (ov !== 1'b1) begin
                            n_fail++;
                            $display("FAIL b2b_valid%0d: got %b want 1", v, ov);
                        end
                        for (int k = 0; k < 6; k++) begin
                            n_chk++;
                            if (od[k] !== vexp[v][k]) begin
                                n_fail++;
                                $display("FAIL b2b_vec%0d_out[%0d]: got %0d want %0d", v, k, $signed(od[k]), $signed(vexp[v][k]));
                            end
                        end
                        if (ov === 1'b1) seen++;
                        @(negedge clk);
                    end
                    n_chk++;
                    if (ov !== 1'b0 || seen != 4) begin
                        n_fail++;
                        $display("FAIL b2b_count: pulses %0d trailing valid %b want 4 and 0", seen, ov);
                    end
                end
            end
        join
    endtask

    task automatic test_saturation;
        @(posedge clk);
        #1 din[0] = 8'h80;
        for (int k = 1; k < 6; k++) din[k] = 8'h7f;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (ov !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_valid: got %b want 1", ov);
        end
        n_chk++;
        if (od[0] !== 8'h7f) begin
            n_fail++;
            $display("FAIL sat_out[0]: got %0d want 127", $signed(od[0]));
        end
        for (int k = 1; k < 6; k++) begin
            n_chk++;
            if (od[k] !== 8'h81) begin
                n_fail++;
                $display("FAIL sat_out[%0d]: got %0d want -127", k, $signed(od[k]));
            end
        end
    endtask

    task automatic test_reset_midflight;
        int pulses = 0;
        @(posedge clk);
        #1 set_in(0);
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 set_in(1);
        valid = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ov) pulses++;
            if (c == 0) begin
                for (int k = 0; k < 6; k++) begin
                    n_chk++;
                    if (od[k] !== 8'h00) begin
                        n_fail++;
                        $display("FAIL midrst_data[%0d]: got %0d want 0", k, $signed(od[k]));
                    end
                end
            end
        end
        n_chk++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL midrst_pulses: got %0d want 0", pulses);
        end
    endtask

    initial begin
        vin[0]  = '{8'hF5, 8'hEC, 8'h1E, 8'hD8, 8'h96, 8'h64};
        vexp[0] = '{8'hEC, 8'hF5, 8'h0B, 8'hF5, 8'hF5, 8'h0B};
        vin[1]  = '{8'h0B, 8'h14, 8'h1E, 8'h28, 8'h32, 8'h0A};
        vexp[1] = '{8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0A, 8'h0B};
        vin[2]  = '{8'hF5, 8'hFE, 8'hFE, 8'hF6, 8'hCE, 8'hF6};
        vexp[2] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
        vin[3]  = '{8'h0B, 8'h0C, 8'hFF, 8'h21, 8'h18, 8'h0C};
        vexp[3] = '{8'hFF, 8'hFF, 8'h0B, 8'hFF, 8'hFF, 8'hFF};
        test_reset;
        for (int v = 0; v < 4; v++) test_single(v);
        test_idle;
        test_back_to_back;
        test_saturation;
        test_reset_midflight;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
